// File: rtl/mult_div_unit_pkg.sv
// Shared MD opcode encoding, FSM state type and the mul/div classification helper
// used by the EX-stage multiply/divide unit and its hazard logic.
package mips_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    MD_ST_IDLE = 1'b0,
    MD_ST_RUN  = 1'b1
  } md_state_e;

  // One bit per opcode; set for the ops that occupy the unit for several cycles.
  localparam logic [15:0] MD_MULDIV_MASK = 16'h001E;

  function automatic logic is_mul_div(input logic [3:0] op);
    return MD_MULDIV_MASK[op];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage view of the multiply/divide unit: issue side from the pipeline,
// status and HI/LO read-back towards hazard logic and writeback.
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        start_busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output start, md_op, rs_val, rt_val,
    input  busy, start_busy, hi, lo, md_out
  );

  modport slave (
    input  start, md_op, rs_val, rt_val,
    output busy, start_busy, hi, lo, md_out
  );
endinterface

// File: rtl/mult_div_unit_arith.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu; a zero divisor
// (and any non-arithmetic op) returns the current HI/LO so the commit is a no-op.
module md_arith
  import mips_defs::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] res_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;
  logic               b_zero;
  logic               s_ovf;

  always_comb begin
    b_zero = (b_i == 32'd0);
    // MIN / -1 overflows; dividing by 1 instead yields the wrapped quotient MIN, remainder 0.
    s_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    div_b  = (b_zero || s_ovf) ? 32'd1 : b_i;

    prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u = {32'd0, a_i} * {32'd0, b_i};
    q_s    = $signed(a_i) / $signed(div_b);
    r_s    = $signed(a_i) % $signed(div_b);
    q_u    = a_i / div_b;
    r_u    = a_i % div_b;

    res_o = {hi_i, lo_i};
    case (op_i)
      MD_MULT:  res_o = prod_s;
      MD_MULTU: res_o = prod_u;
      MD_DIV:   if (!b_zero) res_o = {r_s, q_s};
      MD_DIVU:  if (!b_zero) res_o = {r_u, q_u};
      default:  res_o = {hi_i, lo_i};
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit: result is computed at issue, held pending,
// and committed to HI/LO when the busy countdown expires.
module mult_div_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave md
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [63:0]      arith_res;
  logic             accept;
  logic             is_mul;

  md_arith u_arith (
    .op_i  (md.md_op),
    .a_i   (md.rs_val),
    .b_i   (md.rt_val),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .res_o (arith_res)
  );

  assign accept = md.start && is_mul_div(md.md_op);
  assign is_mul = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      MD_ST_IDLE: begin
        if (accept) begin
          {pend_hi_d, pend_lo_d} = arith_res;
          cnt_d   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          busy_d  = 1'b1;
          state_d = MD_ST_RUN;
        end else if (md.start && (md.md_op == MD_MTHI)) begin
          hi_d = md.rs_val;
        end else if (md.start && (md.md_op == MD_MTLO)) begin
          lo_d = md.rs_val;
        end
      end
      MD_ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          busy_d  = 1'b0;
          state_d = MD_ST_IDLE;
        end
      end
      default: state_d = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Pending result is pure data: reset aborts via the control state, never reads it.
  always_ff @(posedge clk) begin
    pend_hi_q <= pend_hi_d;
    pend_lo_q <= pend_lo_d;
  end

  assign md.busy       = busy_q;
  assign md.start_busy = accept || busy_q;
  assign md.hi         = hi_q;
  assign md.lo         = lo_q;
  assign md.md_out     = (md.md_op == MD_MFHI) ? hi_q :
                         (md.md_op == MD_MFLO) ? lo_q : 32'd0;

endmodule
